// File: rtl/adc_pkg.sv
// Shared types and constants for the SPI ADC sampler: FSM states, frame geometry,
// and the command word shifted out on DIN at the start of each frame.
package adc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CS_SETUP = 2'd1,
    ST_SHIFT    = 2'd2,
    ST_CS_HOLD  = 2'd3
  } state_e;

  localparam int unsigned FRAME_STEPS    = 32;
  localparam int unsigned DATA_BITS      = 10;
  localparam int unsigned FIRST_DATA_BIT = 6;
  localparam int unsigned STEP_W         = 6;
  localparam int unsigned BIT_IDX_W      = 5;
  localparam int unsigned DIV_W          = 8;

  localparam int unsigned CMD_START_BIT = 1;
  localparam int unsigned CMD_SGL_BIT   = 2;
  localparam int unsigned CMD_ODD_BIT   = 3;
  localparam int unsigned CMD_MSBF_BIT  = 4;

  // Registered SPI pin bundle plus the debug step counter and busy flag.
  typedef struct packed {
    logic              cs;
    logic              sclk;
    logic              din;
    logic [STEP_W-1:0] step;
    logic              busy;
  } spi_pins_t;

  // Command bit driven on DIN for a given bit index; odd selects the channel.
  function automatic logic cmd_din(input logic [BIT_IDX_W-1:0] idx, input logic odd);
    logic d;
    d = 1'b0;
    if (idx == BIT_IDX_W'(CMD_START_BIT) || idx == BIT_IDX_W'(CMD_SGL_BIT) ||
        idx == BIT_IDX_W'(CMD_MSBF_BIT)) begin
      d = 1'b1;
    end else if (idx == BIT_IDX_W'(CMD_ODD_BIT)) begin
      d = odd;
    end
    return d;
  endfunction

endpackage

// File: rtl/clk_tick_gen.sv
// Half-bit tick divider: counts enabled cycles and pulses tick_c every CLK_DIV cycles.
module clk_tick_gen
  import adc_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick_c
);

  logic [DIV_W-1:0] div_q;

  assign tick_c = en && (div_q == DIV_W'(CLK_DIV - 1));

  // Synchronous clear restarts the phase so the first tick lands CLK_DIV cycles later.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q <= '0;
    end else if (clr || tick_c) begin
      div_q <= '0;
    end else if (en) begin
      div_q <= div_q + DIV_W'(1);
    end
  end

endmodule

// File: rtl/adc_spi_sampler.sv
// SPI ADC sampler: sends a 5-bit command, clocks in a 10-bit result per frame,
// and reports it with a single-cycle sampleValid after a CS-high hold period.
module adc_spi_sampler
  import adc_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic                 controlCLK,
  input  logic                 rstN,
  input  logic                 start,
  input  logic                 channel,
  output logic                 CS,
  output logic                 SCLK,
  output logic                 DIN,
  input  logic                 DOUT,
  output logic [STEP_W-1:0]    processCounter,
  output logic                 busy,
  output logic [DATA_BITS-1:0] sampleData,
  output logic                 sampleValid
);

  localparam spi_pins_t PINS_RST = '{cs: 1'b1, sclk: 1'b0, din: 1'b0, step: '0, busy: 1'b0};

  state_e                 state_q, state_d;
  spi_pins_t              pins_q, pins_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d, data_d;
  logic                   chan_q, chan_d;
  logic                   valid_d;
  logic                   clr_c;
  logic                   tick_c;
  logic [STEP_W-1:0]      step_inc_c;
  logic [BIT_IDX_W-1:0]   bit_idx_c;

  clk_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk    (controlCLK),
    .rst_n  (rstN),
    .clr    (clr_c),
    .en     (state_q != ST_IDLE),
    .tick_c (tick_c)
  );

  // Next-state and next-output logic; every register holds unless a tick moves it.
  always_comb begin
    state_d    = state_q;
    pins_d     = pins_q;
    shift_d    = shift_q;
    data_d     = sampleData;
    chan_d     = chan_q;
    valid_d    = 1'b0;
    clr_c      = 1'b0;
    step_inc_c = pins_q.step + STEP_W'(1);
    bit_idx_c  = pins_q.step[STEP_W-1:1];

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_CS_SETUP;
          chan_d      = channel;
          clr_c       = 1'b1;
          shift_d     = '0;
          pins_d.cs   = 1'b0;
          pins_d.sclk = 1'b0;
          pins_d.din  = 1'b0;
          pins_d.step = '0;
        end
      end
      ST_CS_SETUP: begin
        if (tick_c) begin
          state_d     = ST_SHIFT;
          pins_d.step = '0;
          pins_d.sclk = 1'b0;
          pins_d.din  = cmd_din('0, chan_q);
        end
      end
      ST_SHIFT: begin
        if (tick_c) begin
          // Sample DOUT when leaving the SCLK-high half of each data bit.
          if (pins_q.step[0] && bit_idx_c >= BIT_IDX_W'(FIRST_DATA_BIT)) begin
            shift_d = {shift_q[DATA_BITS-2:0], DOUT};
          end
          if (pins_q.step == STEP_W'(FRAME_STEPS - 1)) begin
            state_d     = ST_CS_HOLD;
            data_d      = shift_d;
            pins_d.cs   = 1'b1;
            pins_d.sclk = 1'b0;
            pins_d.din  = 1'b0;
            pins_d.step = '0;
          end else begin
            pins_d.step = step_inc_c;
            pins_d.sclk = step_inc_c[0];
            pins_d.din  = cmd_din(step_inc_c[STEP_W-1:1], chan_q);
          end
        end
      end
      ST_CS_HOLD: begin
        if (tick_c) begin
          state_d = ST_IDLE;
          valid_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        pins_d  = PINS_RST;
      end
    endcase

    pins_d.busy = (state_d != ST_IDLE);
  end

  // State register.
  always_ff @(posedge controlCLK) begin
    if (!rstN) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Output, datapath and latched-channel registers.
  always_ff @(posedge controlCLK) begin
    if (!rstN) begin
      pins_q      <= PINS_RST;
      shift_q     <= '0;
      chan_q      <= 1'b0;
      sampleData  <= '0;
      sampleValid <= 1'b0;
    end else begin
      pins_q      <= pins_d;
      shift_q     <= shift_d;
      chan_q      <= chan_d;
      sampleData  <= data_d;
      sampleValid <= valid_d;
    end
  end

  assign CS             = pins_q.cs;
  assign SCLK           = pins_q.sclk;
  assign DIN            = pins_q.din;
  assign processCounter = pins_q.step;
  assign busy           = pins_q.busy;

endmodule

// File: tb/tb_adc_spi_sampler.sv
// Bench for adc_spi_sampler: a cycle-count model of the frame checks both
// instances (CLK_DIV 4 and 2) every cycle; directed frames pin latency and pin shapes.
module tb_adc_spi_sampler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstN;
  logic       start_v   [2];
  logic       channel_v [2];
  logic       dout_v    [2];
  logic [9:0] word_v    [2];
  logic       cs_w [2], sclk_w [2], din_w [2], busy_w [2], valid_w [2];
  logic [5:0] pc_w   [2];
  logic [9:0] data_w [2];

  adc_spi_sampler #(.CLK_DIV(4)) dut0 (
    .controlCLK(clk), .rstN(rstN), .start(start_v[0]), .channel(channel_v[0]),
    .CS(cs_w[0]), .SCLK(sclk_w[0]), .DIN(din_w[0]), .DOUT(dout_v[0]),
    .processCounter(pc_w[0]), .busy(busy_w[0]), .sampleData(data_w[0]),
    .sampleValid(valid_w[0])
  );

  adc_spi_sampler #(.CLK_DIV(2)) dut1 (
    .controlCLK(clk), .rstN(rstN), .start(start_v[1]), .channel(channel_v[1]),
    .CS(cs_w[1]), .SCLK(sclk_w[1]), .DIN(din_w[1]), .DOUT(dout_v[1]),
    .processCounter(pc_w[1]), .busy(busy_w[1]), .sampleData(data_w[1]),
    .sampleValid(valid_w[1])
  );

  int n_assert = 0;
  int n_fail   = 0;
  logic cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic int div_of(input int i);
    return (i == 0) ? 4 : 2;
  endfunction

  function automatic logic cmd_bit(input int idx, input logic ch);
    case (idx)
      1, 2, 4: return 1'b1;
      3:       return ch;
      default: return 1'b0;
    endcase
  endfunction

  // Model: a frame is just "edges elapsed since the accepting edge".
  logic       m_active [2];
  int         m_n      [2];
  logic       m_chan   [2];
  logic [9:0] m_word   [2];
  logic [9:0] m_data   [2];
  logic       m_valid  [2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rstN) begin
        m_active[i] <= 1'b0;
        m_n[i]      <= 0;
        m_data[i]   <= '0;
        m_valid[i]  <= 1'b0;
      end else if (m_active[i]) begin
        m_n[i]     <= m_n[i] + 1;
        m_valid[i] <= (m_n[i] + 1 == 34 * div_of(i));
        if (m_n[i] + 1 == 33 * div_of(i)) m_data[i] <= m_word[i];
        if (m_n[i] + 1 == 34 * div_of(i)) m_active[i] <= 1'b0;
      end else begin
        m_valid[i] <= 1'b0;
        if (start_v[i]) begin
          m_active[i] <= 1'b1;
          m_n[i]      <= 0;
          m_chan[i]   <= channel_v[i];
          m_word[i]   <= word_v[i];
        end
      end
    end
  end

  // Per-cycle compare against the model, and ADC-side DOUT drive from the model's step.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int   d, pc, bi;
      logic in_shift, e_cs, e_sclk, e_din;
      d        = div_of(i);
      in_shift = m_active[i] && (m_n[i] >= d) && (m_n[i] < 33 * d);
      pc       = in_shift ? (m_n[i] / d - 1) : 0;
      bi       = pc / 2;
      e_cs     = !(m_active[i] && (m_n[i] < 33 * d));
      e_sclk   = in_shift && (pc % 2 == 1);
      e_din    = in_shift ? cmd_bit(bi, m_chan[i]) : 1'b0;
      if (cmp_en) begin
        chk($sformatf("cs[%0d]", i),    32'(cs_w[i]),    32'(e_cs));
        chk($sformatf("sclk[%0d]", i),  32'(sclk_w[i]),  32'(e_sclk));
        chk($sformatf("din[%0d]", i),   32'(din_w[i]),   32'(e_din));
        chk($sformatf("pc[%0d]", i),    32'(pc_w[i]),    32'(pc));
        chk($sformatf("busy[%0d]", i),  32'(busy_w[i]),  32'(m_active[i]));
        chk($sformatf("valid[%0d]", i), 32'(valid_w[i]), 32'(m_valid[i]));
        chk($sformatf("data[%0d]", i),  32'(data_w[i]),  32'(m_data[i]));
      end
      dout_v[i] = (in_shift && bi >= 6) ? m_word[i][15 - bi] : 1'b0;
    end
  end

  // One frame from an idle DUT; optional re-pulse of start when processCounter hits retrig.
  task automatic do_frame(input int i, input logic ch, input logic [9:0] w, input int retrig,
                          output int lat, output int cs_low, output logic [15:0] dseq,
                          output int vcnt);
    logic prev_sclk;
    logic rt_done;
    int   c;
    word_v[i]    = w;
    channel_v[i] = ch;
    start_v[i]   = 1'b1;
    @(negedge clk);
    start_v[i] = 1'b0;
    lat = -1; cs_low = 0; dseq = '0; vcnt = 0; prev_sclk = 1'b0; rt_done = 1'b0; c = 0;
    repeat (400) begin
      if (valid_w[i]) begin
        vcnt++;
        if (lat < 0) lat = c;
      end
      if (!cs_w[i]) cs_low++;
      if (sclk_w[i] && !prev_sclk) dseq = {dseq[14:0], din_w[i]};
      prev_sclk = sclk_w[i];
      if (retrig >= 0 && int'(pc_w[i]) == retrig && !rt_done) begin
        start_v[i] = 1'b1;
        rt_done    = 1'b1;
      end else begin
        start_v[i] = 1'b0;
      end
      if (lat >= 0 && c >= lat + 8) break;
      @(negedge clk);
      c++;
    end
    start_v[i] = 1'b0;
  endtask

  initial begin
    int lat, csl, vc, c, run, min_gap;
    logic [15:0] dseq;
    logic found, seen_low;
    int vtimes[$];

    rstN = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start_v[i] = 1'b0; channel_v[i] = 1'b0; dout_v[i] = 1'b0; word_v[i] = '0;
      m_active[i] = 1'b0; m_n[i] = 0; m_chan[i] = 1'b0; m_word[i] = '0;
      m_data[i] = '0; m_valid[i] = 1'b0;
    end
    @(negedge clk);
    cmp_en = 1'b1;
    repeat (2) @(negedge clk);

    chk("rst_cs",    32'(cs_w[0]),    32'd1);
    chk("rst_sclk",  32'(sclk_w[0]),  32'd0);
    chk("rst_din",   32'(din_w[0]),   32'd0);
    chk("rst_pc",    32'(pc_w[0]),    32'd0);
    chk("rst_busy",  32'(busy_w[0]),  32'd0);
    chk("rst_valid", 32'(valid_w[0]), 32'd0);
    chk("rst_data",  32'(data_w[0]),  32'd0);
    rstN = 1'b1;
    repeat (3) @(negedge clk);

    do_frame(0, 1'b0, 10'h2A5, -1, lat, csl, dseq, vc);
    chk("f1_latency", 32'(lat), 32'd136);
    chk("f1_data",    32'(data_w[0]), 32'h2A5);
    chk("f1_vcount",  32'(vc), 32'd1);
    chk("f1_cs_low",  32'(csl), 32'd132);
    chk("f1_din_seq", 32'(dseq), 32'h6800);

    do_frame(0, 1'b1, 10'h155, -1, lat, csl, dseq, vc);
    chk("f2_din_seq", 32'(dseq), 32'h7800);
    chk("f2_cs_low",  32'(csl), 32'd132);
    chk("f2_data",    32'(data_w[0]), 32'h155);

    do_frame(0, 1'b0, 10'h0F0, 10, lat, csl, dseq, vc);
    chk("retrig_vcount",  32'(vc), 32'd1);
    chk("retrig_latency", 32'(lat), 32'd136);
    chk("retrig_cs_low",  32'(csl), 32'd132);
    chk("retrig_data",    32'(data_w[0]), 32'h0F0);
    chk("retrig_idle",    32'(busy_w[0]), 32'd0);

    // Abort mid-frame with reset.
    word_v[0] = 10'h3C3; channel_v[0] = 1'b0; start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    found = 1'b0;
    repeat (300) begin
      if (pc_w[0] == 6'd20) begin found = 1'b1; break; end
      @(negedge clk);
    end
    chk("abort_reached_pc20", 32'(found), 32'd1);
    rstN = 1'b0;
    @(negedge clk);
    chk("abort_cs",    32'(cs_w[0]),    32'd1);
    chk("abort_sclk",  32'(sclk_w[0]),  32'd0);
    chk("abort_pc",    32'(pc_w[0]),    32'd0);
    chk("abort_valid", 32'(valid_w[0]), 32'd0);
    chk("abort_data",  32'(data_w[0]),  32'd0);
    rstN = 1'b1;
    vc = 0;
    repeat (200) begin
      if (valid_w[0]) vc++;
      @(negedge clk);
    end
    chk("abort_no_valid", 32'(vc), 32'd0);

    // Start held high: back-to-back frames.
    word_v[0] = 10'h3FF; channel_v[0] = 1'b0; start_v[0] = 1'b1;
    @(negedge clk);
    run = 0; min_gap = 1000; seen_low = 1'b0;
    for (c = 0; c < 500; c++) begin
      if (valid_w[0]) begin
        vtimes.push_back(c);
        chk("b2b_data", 32'(data_w[0]), 32'h3FF);
      end
      if (cs_w[0]) begin
        run++;
      end else begin
        if (seen_low && run > 0 && run < min_gap) min_gap = run;
        seen_low = 1'b1;
        run = 0;
      end
      @(negedge clk);
    end
    start_v[0] = 1'b0;
    chk("b2b_frames_ge3", 32'(vtimes.size() >= 3), 32'd1);
    if (vtimes.size() >= 2) begin
      chk("b2b_first_valid", 32'(vtimes[0]), 32'd136);
      chk("b2b_period", 32'(vtimes[1] - vtimes[0]), 32'd137);
    end
    chk("b2b_cs_gap_ge4", 32'(min_gap >= 4 && min_gap < 1000), 32'd1);
    found = 1'b0;
    repeat (200) begin
      if (!busy_w[0]) begin found = 1'b1; break; end
      @(negedge clk);
    end
    chk("b2b_returns_idle", 32'(found), 32'd1);
    repeat (2) @(negedge clk);

    do_frame(1, 1'b0, 10'h001, -1, lat, csl, dseq, vc);
    chk("div2_latency", 32'(lat), 32'd68);
    chk("div2_data",    32'(data_w[1]), 32'h001);
    chk("div2_cs_low",  32'(csl), 32'd66);
    chk("div2_vcount",  32'(vc), 32'd1);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
